// File: rtl/note_judge_ctrl.sv
// rtl/note_judge_ctrl.sv - beat judgement controller driving a shared 1-bit equality comparator
// Optional streak tracking: define NOTE_JUDGE_STREAK_EN.
module note_judge_ctrl #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat,
  input  logic [LANES-1:0] expected,
  input  logic [LANES-1:0] keys,
  input  logic             clear,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] streak
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SCAN, JUDGE} state_t;

  state_t           state, state_nx;
  logic [LANES-1:0] exp_sr, key_sr;
  logic [IDX_W-1:0] idx;
  logic             match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (beat) state_nx = SCAN;
      SCAN:    if (idx == LAST_IDX) state_nx = JUDGE;
      JUDGE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    cmp_a = 1'b0;
    cmp_b = 1'b0;
    case (state)
      SCAN: begin
        busy  = 1'b1;
        cmp_a = exp_sr[0];
        cmp_b = key_sr[0];
      end
      JUDGE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Patterns are snapshotted at beat so later input changes cannot disturb the scan.
  // hit is registered on the last scan edge so it is already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_sr <= '0;
      key_sr <= '0;
      idx    <= '0;
      match  <= 1'b0;
      hit    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (beat) begin
          exp_sr <= expected;
          key_sr <= keys;
          idx    <= '0;
          match  <= 1'b1;
        end
        SCAN: begin
          exp_sr <= exp_sr >> 1;
          key_sr <= key_sr >> 1;
          idx    <= idx + IDX_W'(1);
          match  <= match & cmp_eq;
          if (idx == LAST_IDX) hit <= match & cmp_eq;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (clear) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == JUDGE) begin
      if (hit) begin
        if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_W'(1);
      end else begin
        if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_W'(1);
      end
    end
  end

`ifdef NOTE_JUDGE_STREAK_EN
  logic [CNT_W-1:0] streak_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 streak_q <= '0;
    else if (clear)          streak_q <= '0;
    else if (state == JUDGE) begin
      if (!hit)                       streak_q <= '0;
      else if (streak_q != CNT_MAX)   streak_q <= streak_q + CNT_W'(1);
    end
  end

  assign streak = streak_q;
`else
  assign streak = '0;
`endif

endmodule

// File: tb/tb_note_judge_ctrl.sv
// tb/tb_note_judge_ctrl.sv - directed self-checking bench for note_judge_ctrl
module tb_note_judge_ctrl;

`ifdef NOTE_JUDGE_STREAK_EN
  localparam int SE = 1;
`else
  localparam int SE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       beat = 1'b0;
  logic [3:0] expected = '0;
  logic [3:0] keys = '0;
  logic       clear = 1'b0;

  logic       cmp_a, cmp_b, cmp_eq, busy, done, hit;
  logic [7:0] hit_count, miss_count, streak;

  logic       cmp_a2, cmp_b2, cmp_eq2, busy2, done2, hit2;
  logic [1:0] hit_count2, miss_count2, streak2;

  int n_vec = 0;
  int n_err = 0;
  int n_done;
  int done_step;

  always #5 clk = ~clk;

  assign cmp_eq  = (cmp_a == cmp_b);
  assign cmp_eq2 = (cmp_a2 == cmp_b2);

  note_judge_ctrl #(.LANES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .beat(beat), .expected(expected), .keys(keys), .clear(clear),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq), .busy(busy), .done(done), .hit(hit),
    .hit_count(hit_count), .miss_count(miss_count), .streak(streak)
  );

  note_judge_ctrl #(.LANES(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .beat(beat), .expected(expected), .keys(keys), .clear(clear),
    .cmp_a(cmp_a2), .cmp_b(cmp_b2), .cmp_eq(cmp_eq2), .busy(busy2), .done(done2), .hit(hit2),
    .hit_count(hit_count2), .miss_count(miss_count2), .streak(streak2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a beat and run through JUDGE and one idle cycle (6 negedges).
  task automatic run_beat(input logic [3:0] e, input logic [3:0] k, input logic exp_hit,
                          input string tag);
    beat = 1'b1; expected = e; keys = k;
    for (int s = 1; s <= 6; s++) begin
      @(negedge clk);
      beat = 1'b0;
      if (s == 5) begin
        chk({tag, "_done"}, done, 1);
        chk({tag, "_hit"}, hit, exp_hit);
      end
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_cmp", {cmp_a, cmp_b}, 0);
    chk("rst_cnt", {hit_count, miss_count, streak}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Matching beat; keys disturbed after capture must not matter
    beat = 1'b1; expected = 4'b1010; keys = 4'b1010;
    @(negedge clk);
    beat = 1'b0; keys = 4'b0000; expected = 4'b1111;
    chk("m_busy1", busy, 1);
    chk("m_cmp1", {cmp_a, cmp_b}, 2'b00);
    @(negedge clk);
    chk("m_cmp2", {cmp_a, cmp_b}, 2'b11);
    @(negedge clk);
    @(negedge clk);
    chk("m_done4", done, 0);
    @(negedge clk);
    chk("m_done5", done, 1);
    chk("m_hit5", hit, 1);
    chk("m_cmp5", {cmp_a, cmp_b}, 2'b00);
    @(negedge clk);
    chk("m_done6", done, 0);
    chk("m_busy6", busy, 0);
    chk("m_hitc", hit_count, 1);
    chk("m_missc", miss_count, 0);
    chk("m_streak", streak, SE);

    // Mismatch beat and comparator drive sequence
    beat = 1'b1; expected = 4'b0110; keys = 4'b0111;
    @(negedge clk);
    beat = 1'b0;
    chk("x_cmp1", {cmp_a, cmp_b}, 2'b01);
    @(negedge clk);
    chk("x_cmp2", {cmp_a, cmp_b}, 2'b11);
    @(negedge clk);
    chk("x_cmp3", {cmp_a, cmp_b}, 2'b11);
    @(negedge clk);
    chk("x_cmp4", {cmp_a, cmp_b}, 2'b00);
    @(negedge clk);
    chk("x_done", done, 1);
    chk("x_hit", hit, 0);
    @(negedge clk);
    chk("x_hitc", hit_count, 1);
    chk("x_missc", miss_count, 1);
    chk("x_streak", streak, 0);

    // Beats during SCAN and during JUDGE are ignored
    n_done = 0; done_step = -1;
    beat = 1'b1; expected = 4'b1111; keys = 4'b1111;
    for (int s = 1; s <= 12; s++) begin
      @(negedge clk);
      beat = (s == 2) || (s == 5);
      if (done) begin
        n_done++;
        done_step = s;
      end
    end
    beat = 1'b0;
    chk("ign_ndone", n_done, 1);
    chk("ign_step", done_step, 5);
    chk("ign_hitc", hit_count, 2);

    // Saturation on the CNT_W=2 instance
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_cnt", {hit_count, miss_count, streak}, 0);
    for (int b = 0; b < 5; b++) run_beat(4'b0101, 4'b0101, 1'b1, "sat");
    chk("sat_hitc2", hit_count2, 3);
    chk("sat_streak2", streak2, 3 * SE);
    chk("sat_hitc", hit_count, 5);
    chk("sat_streak", streak, 5 * SE);

    // Reset during the third SCAN cycle
    beat = 1'b1; expected = 4'b0011; keys = 4'b0011;
    @(negedge clk);
    beat = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ra_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("ra_busy", busy, 0);
    chk("ra_hit", hit, 0);
    chk("ra_cnt", {hit_count, miss_count, streak}, 0);
    chk("ra_cmp", {cmp_a, cmp_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("ra_nodone", n_done, 0);
    run_beat(4'b1000, 4'b0000, 1'b0, "ra_next");
    chk("ra_missc", miss_count, 1);
    chk("ra_hitc", hit_count, 0);

    // clear in the JUDGE cycle of a hit
    beat = 1'b1; expected = 4'b1001; keys = 4'b1001;
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk);
      beat = 1'b0;
    end
    chk("cj_done", done, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("cj_hit", hit, 1);
    chk("cj_hitc", hit_count, 0);
    chk("cj_missc", miss_count, 0);
    chk("cj_streak", streak, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/note_judge_ctrl.md
NOTE_JUDGE_CTRL -- requirements
Module: note_judge_ctrl

Interface
REQ-001 Parameter LANES, default 4, number of note lanes judged per beat (2..8).
REQ-002 Parameter CNT_W, default 8, width of hit/miss/streak counters.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 beat  input  1  one-cycle pulse requesting judgement of the current beat.
REQ-006 expected  input  LANES  expected note pattern (1 = key must be pressed).
REQ-007 keys  input  LANES  debounced player key state.
REQ-008 clear  input  1  synchronous clear of score counters.
REQ-009 cmp_a  output  1  expected bit driven to the shared external 1-bit equality comparator.
REQ-010 cmp_b  output  1  key bit driven to the shared comparator.
REQ-011 cmp_eq  input  1  comparator result (1 = equal), combinational from cmp_a/cmp_b.
REQ-012 busy  output  1  high while a judgement is in progress.
REQ-013 done  output  1  one-cycle pulse when a judgement completes.
REQ-014 hit  output  1  result of the last judgement (1 = all lanes matched); valid from done onward.
REQ-015 hit_count  output  CNT_W  saturating count of hit beats.
REQ-016 miss_count  output  CNT_W  saturating count of missed beats.
REQ-017 streak  output  CNT_W  current consecutive-hit count (see REQ-035).

Function
REQ-018 FSM states: IDLE, SCAN, JUDGE; one-hot or binary is implementer's choice.
REQ-019 IDLE: on beat=1, latch expected and keys into LANES-bit shift registers, clear lane index and match flag (set to 1), go to SCAN.
REQ-020 beat while not in IDLE (including the JUDGE cycle) SHALL be ignored; no queuing.
REQ-021 SCAN: each cycle drive cmp_a/cmp_b from lane index i (LSB first); match flag <= match flag AND cmp_eq.
REQ-022 SCAN lasts exactly LANES cycles, then JUDGE; no early exit on mismatch.
REQ-023 In IDLE and JUDGE, cmp_a and cmp_b SHALL be 0.
REQ-024 JUDGE (one cycle): hit <= match flag; increment hit_count if hit else miss_count; assert done; return to IDLE.
REQ-025 Latency: done asserts LANES+1 cycles after the cycle beat is sampled; busy high for those LANES+1 cycles.
REQ-026 Counters saturate at 2^CNT_W-1; no wrap-around.
REQ-027 clear in any state zeroes hit_count, miss_count, streak next cycle; does not abort a scan.
REQ-028 clear coincident with JUDGE: clear wins; counters read 0 after that edge, hit still updated.
REQ-029 keys/expected changes after beat capture SHALL not affect the in-progress judgement.

Reset
REQ-030 rst=1 asynchronously forces IDLE, busy=0, done=0, hit=0, cmp_a=0, cmp_b=0, all counters 0.
REQ-031 rst mid-SCAN aborts the judgement; no counter update, no done pulse.
REQ-032 After rst deasserts, first beat is accepted on the next rising edge.

Configuration
REQ-033 Macro NOTE_JUDGE_STREAK_EN selects streak tracking.
REQ-034 Without NOTE_JUDGE_STREAK_EN: streak output tied to 0, no streak register synthesised.
REQ-035 With NOTE_JUDGE_STREAK_EN: in JUDGE, streak increments (saturating) on hit, resets to 0 on miss; cleared by rst and clear.

Verification
REQ-036 LANES=4, beat with expected=4'b1010, keys=4'b1010 -> done 5 cycles later, hit=1, hit_count=1, miss_count=0, streak=1.
REQ-037 expected=4'b0110, keys=4'b0111 -> hit=0, miss_count=1, streak=0; cmp_a/cmp_b sequence 0/1,1/1,1/1,0/0 over the 4 SCAN cycles.
REQ-038 beat pulses on cycles 1 and 3 -> only one judgement, single done at cycle 6.
REQ-039 CNT_W=2, 5 consecutive hits -> hit_count=3, streak=3 (saturated).
REQ-040 rst asserted during 3rd SCAN cycle -> outputs zero immediately, no done; next beat judged normally.
REQ-041 clear asserted in the JUDGE cycle of a hit -> hit=1, hit_count=0, streak=0.
